// File: rtl/kuz_pkg.sv
// Shared Kuznyechik (GOST R34.12-2015) definitions for the forward and inverse L stages:
// GF(2^8) reduction constant, the l coefficient vector, round count and FSM state encoding.
package kuz_pkg;

  // p(x) = x^8 + x^7 + x^6 + x + 1; low byte folded back in on overflow
  localparam logic [7:0] GfRed = 8'hC3;

  // R / R^-1 iterations per block
  localparam int unsigned Rounds = 16;

  // Forward l coefficients for a15..a0, in that order
  localparam logic [7:0] LVec [16] = '{
    8'h94, 8'h20, 8'h85, 8'h10, 8'hC2, 8'hC0, 8'h01, 8'hFB,
    8'h01, 8'hC0, 8'hC2, 8'h10, 8'h85, 8'h20, 8'h94, 8'h01
  };

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } kuz_state_e;

  // Coefficient for byte a_idx in the inverse combiner: R^-1 feeds l with
  // (a14..a0, a15), so a15 takes the last entry and a14..a0 take entries 0..14.
  function automatic logic [7:0] l_inv_coef(input int unsigned idx);
    if (idx == 15) begin
      return LVec[15];
    end
    return LVec[14 - idx];
  endfunction

endpackage

// File: rtl/gf256_mul_const.sv
// Combinational multiply of a byte by a constant in GF(2^8) mod p(x), shift-and-reduce.
module gf256_mul_const
  import kuz_pkg::*;
#(
  parameter logic [7:0] Coef = 8'h01
) (
  input  logic [7:0] a_i,
  output logic [7:0] p_o
);

  logic [7:0] x;
  logic [7:0] acc;

  // Accumulate a*x^b for each set coefficient bit, reducing x after every doubling
  always_comb begin
    x   = a_i;
    acc = 8'h00;
    for (int b = 0; b < 8; b++) begin
      if (Coef[b]) begin
        acc = acc ^ x;
      end
      x = {x[6:0], 1'b0} ^ (x[7] ? GfRed : 8'h00);
    end
    p_o = acc;
  end

endmodule

// File: rtl/l_inv_stage.sv
// Iterative Kuznyechik inverse linear transform L^-1 over a 128-bit block.
// One R^-1 round per enabled clock; with L_INV_UNROLL2_EN defined, two rounds are chained
// per enabled clock (half the latency, identical results).
// Handshake: valid/ready on both sides, one block in flight. Synchronous active-low reset.
module l_inv_stage
  import kuz_pkg::*;
#(
  parameter int unsigned W      = 128,   // only 128 is meaningful
  parameter int unsigned ROUNDS = Rounds
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] DI,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] DO
);

`ifdef L_INV_UNROLL2_EN
  localparam int unsigned Step = 2;
`else
  localparam int unsigned Step = 1;
`endif

  localparam int unsigned CntW = 5;

  kuz_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    data_q, data_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  // stage[0] is the register; stage[s+1] is stage[s] after one R^-1
  logic [W-1:0] stage [Step+1];
  logic [7:0]   prod  [Step][16];
  logic [7:0]   comb  [Step];

  assign stage[0] = data_q;

  for (genvar s = 0; s < Step; s++) begin : g_round
    for (genvar i = 0; i < 16; i++) begin : g_mul
      gf256_mul_const #(
        .Coef(l_inv_coef(i))
      ) u_mul (
        .a_i(stage[s][8*i +: 8]),
        .p_o(prod[s][i])
      );
    end

    // XOR tree forming the new low byte c of this round
    always_comb begin
      comb[s] = 8'h00;
      for (int i = 0; i < 16; i++) begin
        comb[s] = comb[s] ^ prod[s][i];
      end
    end

    // Shift out a15, append c as the new a0
    assign stage[s+1] = {stage[s][W-9:0], comb[s]};
  end

  // Next-state logic for the handshake FSM and round datapath
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          state_d    = StBusy;
          data_d     = DI;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end
      StBusy: begin
        if (enable) begin
          data_d = stage[Step];
          cnt_d  = cnt_q + CntW'(Step);
          // Counter is wide enough to hold ROUNDS, so it never wraps into an extra round
          if (cnt_d == CntW'(ROUNDS)) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      data_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign DO        = data_q;

endmodule

// File: tb/tb_l_inv_stage.sv
// Directed self-checking bench for l_inv_stage using GOST R34.12-2015 L test vectors.
module tb_l_inv_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] DI;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] DO;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef L_INV_UNROLL2_EN
  localparam int LatNom = 9;
  localparam int LatTog = 17;
`else
  localparam int LatNom = 17;
  localparam int LatTog = 33;
`endif

  localparam logic [127:0] VecA = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
  localparam logic [127:0] VecB = 128'h64a59400000000000000000000000000;
  localparam logic [127:0] VecC = 128'he6a8094fee0aa204fd97bcb0b44b8580;
  localparam logic [127:0] VecD = 128'h0e93691a0cfc60408b7b68f66b513c13;
  localparam logic [127:0] VecE = 128'h79d26221b87b584cd42fbc4ffea5de9a;

  l_inv_stage u_dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .DI       (DI),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .DO       (DO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block, wait for the result, optionally hold it under backpressure, then drain.
  task automatic run_block(input logic [127:0] di, input logic [127:0] exp_do, input int exp_lat,
                           input bit toggle, input int hold, input bit junk);
    int lat;
    chk("in_ready_idle", 128'(in_ready), 128'd1);
    DI        = di;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    if (toggle) enable = 1'b0;
    tick();
    chk("in_ready_busy", 128'(in_ready), 128'd0);
    if (junk) DI = ~di;
    else in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (toggle) enable = (lat % 2 == 0);
      tick();
      lat++;
    end
    enable = 1'b1;
    chk("latency", 128'(lat), 128'(exp_lat));
    chk("result", DO, exp_do);
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 128'(out_valid), 128'd1);
      chk("hold_data", DO, exp_do);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("out_valid_clear", 128'(out_valid), 128'd0);
  endtask

  initial begin
    rst       = 1'b0;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    DI        = '0;
    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_do", DO, 128'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Basic vector
    run_block(VecA, VecB, LatNom, 1'b0, 0, 1'b0);
    // Back-to-back chain
    run_block(VecC, VecD, LatNom, 1'b0, 0, 1'b0);
    run_block(VecD, VecE, LatNom, 1'b0, 0, 1'b0);
    run_block(VecE, VecA, LatNom, 1'b0, 0, 1'b0);
    // Backpressure for 10 cycles
    run_block(VecA, VecB, LatNom, 1'b0, 10, 1'b0);
    // Enable toggling every cycle in BUSY
    run_block(VecC, VecD, LatTog, 1'b1, 0, 1'b0);
    // in_valid held with different data while BUSY/DONE
    run_block(VecC, VecD, LatNom, 1'b0, 3, 1'b1);
    // Zero input
    run_block(128'd0, 128'd0, LatNom, 1'b0, 0, 1'b0);

    // Reset at round 7
    DI       = VecD;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b0;
    tick();
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_do", DO, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd0);
    rst = 1'b1;
    tick();
    chk("midrst_release_in_ready", 128'(in_ready), 128'd1);
    run_block(VecD, VecE, LatNom, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
